// File: rtl/cnt_ser_pkg.sv
// Shared constants for the counter-pair serializer: state encoding, default header, byte width.
// Optional checksum byte is enabled by defining CNT_SER_CSUM_EN.
package cnt_ser_pkg;

  localparam int BYTE_W = 8;
  localparam logic [7:0] HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/cnt_ser_byte_mux.sv
// Combinational byte select from the {snap1, snap0} snapshot, byte 0 = snap0[7:0].
import cnt_ser_pkg::*;

module cnt_ser_byte_mux #(
  parameter int CNT_W = 64,
  parameter int IDX_W = 4
) (
  input  logic [2*CNT_W-1:0] snap,
  input  logic [IDX_W-1:0]   idx,
  output logic [BYTE_W-1:0]  byte_o
);

  localparam int NBYTES = (2 * CNT_W) / BYTE_W;

  logic [BYTE_W-1:0] bytes [NBYTES];

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign bytes[gi] = snap[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  always_comb begin
    byte_o = '0;
    if (32'(idx) < NBYTES) begin
      byte_o = bytes[idx];
    end
  end

endmodule

// File: rtl/cnt_pair_serializer.sv
// Snapshots two counters on Trig and streams header, counter bytes (LSB first) and an
// optional XOR checksum (macro CNT_SER_CSUM_EN) over a byte-wide valid/ready link.
import cnt_ser_pkg::*;

module cnt_pair_serializer #(
  parameter int         CNT_W  = 64,
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Trig,
  input  logic [CNT_W-1:0] Cnt0,
  input  logic [CNT_W-1:0] Cnt1,
  output logic [7:0]       Dout,
  output logic             Valid,
  input  logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic             Drop
);

  localparam int NB     = CNT_W / BYTE_W;
  localparam int NDATA  = 2 * NB;
  localparam int IDX_W  = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDATA - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  snap0_q, snap0_d;
  logic [CNT_W-1:0]  snap1_q, snap1_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              drop_q, drop_d;
`ifdef CNT_SER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [7:0] data_byte;
  logic       xfer;

  cnt_ser_byte_mux #(
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_byte_mux (
    .snap   ({snap1_q, snap0_q}),
    .idx    (idx_q),
    .byte_o (data_byte)
  );

  // Outputs depend only on registered state, so Dout is stable while a byte is stalled.
  always_comb begin
    Valid = 1'b0;
    Dout  = 8'h00;
    case (state_q)
      ST_HDR: begin
        Valid = 1'b1;
        Dout  = HEADER;
      end
      ST_DATA: begin
        Valid = 1'b1;
        Dout  = data_byte;
      end
`ifdef CNT_SER_CSUM_EN
      ST_CSUM: begin
        Valid = 1'b1;
        Dout  = csum_q;
      end
`endif
      default: ;
    endcase
  end

  assign Busy = (state_q != ST_IDLE);
  assign Done = (state_q == ST_FIN);
  assign Drop = drop_q;
  assign xfer = Valid && Ready;

  always_comb begin
    state_d = state_q;
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    idx_d   = idx_q;
    drop_d  = drop_q | (Trig && (state_q != ST_IDLE));
`ifdef CNT_SER_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Trig) begin
          snap0_d = Cnt0;
          snap1_d = Cnt1;
          idx_d   = '0;
          state_d = ST_HDR;
`ifdef CNT_SER_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      ST_HDR: begin
        if (xfer) begin
          idx_d   = '0;
          state_d = ST_DATA;
`ifdef CNT_SER_CSUM_EN
          csum_d  = HEADER;
`endif
        end
      end
      ST_DATA: begin
        if (xfer) begin
`ifdef CNT_SER_CSUM_EN
          csum_d = csum_q ^ data_byte;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef CNT_SER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef CNT_SER_CSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      snap0_q <= '0;
      snap1_q <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
`ifdef CNT_SER_CSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
`ifdef CNT_SER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
